crtc_mode_sequencer: RTL

//  Shares the UM6845R register port between the host CPU I/O path and an internal mode loader.
//  On reset (optional) or on load_req, the loader writes a 16-entry CRTC register table (R0..R15)
//  for the selected video mode, then restores the CPU's last-selected index.

---
 rtl/crtc_modes_pkg.sv | 27 ++
 rtl/crtc_mode_rom.sv | 16 +
 rtl/crtc_mode_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/crtc_modes_pkg.sv
// Shared definitions for the CRTC mode sequencer: mode encodings, sequencer
// states and the per-mode R0..R11 register table (R12..R15 load as 00).
package crtc_modes_pkg;

  localparam logic [1:0] MODE_CGA40  = 2'd0;
  localparam logic [1:0] MODE_CGA80  = 2'd1;
  localparam logic [1:0] MODE_CGAGFX = 2'd2;
  localparam logic [1:0] MODE_MDA    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IDX,
    ST_DATA,
    ST_GAP,
    ST_RESTORE
  } seq_state_t;

  localparam int unsigned TABLE_REGS = 12;

  localparam logic [7:0] MODE_TABLE [4][TABLE_REGS] = '{
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
    '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07},
    '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19, 8'h02, 8'h0D, 8'h0B, 8'h0C}
  };

endpackage

// File: rtl/crtc_mode_rom.sv
// Combinational (mode, register index) -> CRTC register value lookup.
module crtc_mode_rom
  import crtc_modes_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [3:0] i_idx,
  output logic [7:0] o_data
);

  always_comb begin
    o_data = '0;
    if (i_idx < 4'(TABLE_REGS))
      o_data = MODE_TABLE[i_mode][i_idx];
  end

endmodule

// File: rtl/crtc_mode_sequencer.sv
// Arbitrates the UM6845R register port between the CPU and a mode-table loader;
// the CPU always wins and the loader re-issues an index write it may have lost.
module crtc_mode_sequencer
  import crtc_modes_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned GAP_CYCLES    = 0,
  parameter int unsigned AUTOLOAD_EN   = 1,
  parameter int unsigned AUTOLOAD_MODE = 1
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       cpu_en,
  input  logic       cpu_ncs,
  input  logic       cpu_rnw,
  input  logic       cpu_rs,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  input  logic       load_req,
  input  logic [1:0] mode_sel,
  output logic       load_busy,
  output logic       load_done,
  output logic       crtc_enable,
  output logic       crtc_ncs,
  output logic       crtc_rnw,
  output logic       crtc_rs,
  output logic [7:0] crtc_di,
  input  logic [7:0] crtc_do
);

  localparam logic [3:0] CNT_LAST  = 4'(NUM_REGS - 1);
  localparam logic [3:0] GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [1:0] AUTO_MODE = 2'(AUTOLOAD_MODE);

  seq_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_gap, w_gap_nxt;
  logic [1:0] r_mode, w_mode_nxt;
  logic [4:0] r_shadow, w_shadow_nxt;
  logic       r_auto;
  logic       r_done, w_done_nxt;

  logic       r_ld_en, r_ld_ncs, r_ld_rnw, r_ld_rs;
  logic [7:0] r_ld_di;
  logic       w_ld_en, w_ld_ncs, w_ld_rnw, w_ld_rs;
  logic [7:0] w_ld_di;
  logic [7:0] w_rom;

  logic w_grant;
  logic w_req;

  assign w_grant = cpu_en & ~cpu_ncs;
  assign w_req   = load_req | r_auto;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_gap_nxt    = r_gap;
    w_mode_nxt   = r_mode;
    w_shadow_nxt = r_shadow;
    w_done_nxt   = 1'b0;
    if (w_grant && !cpu_rnw && !cpu_rs)
      w_shadow_nxt = cpu_di[4:0];
    if (w_req) begin
      w_state_nxt = ST_IDX;
      w_cnt_nxt   = '0;
      w_gap_nxt   = '0;
      w_mode_nxt  = load_req ? mode_sel : AUTO_MODE;
    end else if (w_grant) begin
      // CPU may have moved the index register: redo the index write first
      if (r_state == ST_DATA)
        w_state_nxt = ST_IDX;
    end else begin
      case (r_state)
        ST_IDX: w_state_nxt = ST_DATA;
        ST_DATA: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_RESTORE;
          end else begin
            w_cnt_nxt   = r_cnt + 4'd1;
            w_gap_nxt   = '0;
            w_state_nxt = (GAP_CYCLES == 0) ? ST_IDX : ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST)
            w_state_nxt = ST_IDX;
          else
            w_gap_nxt = r_gap + 4'd1;
        end
        ST_RESTORE: begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  crtc_mode_rom u_rom (
    .i_mode (w_mode_nxt),
    .i_idx  (w_cnt_nxt),
    .o_data (w_rom)
  );

  // Loader bus drive is decoded from the next state so it can be registered
  always_comb begin
    w_ld_en  = 1'b0;
    w_ld_ncs = 1'b1;
    w_ld_rnw = 1'b1;
    w_ld_rs  = 1'b0;
    w_ld_di  = '0;
    case (w_state_nxt)
      ST_IDX: begin
        w_ld_en = 1'b1; w_ld_ncs = 1'b0; w_ld_rnw = 1'b0;
        w_ld_di = {4'd0, w_cnt_nxt};
      end
      ST_DATA: begin
        w_ld_en = 1'b1; w_ld_ncs = 1'b0; w_ld_rnw = 1'b0; w_ld_rs = 1'b1;
        w_ld_di = w_rom;
      end
      ST_RESTORE: begin
        w_ld_en = 1'b1; w_ld_ncs = 1'b0; w_ld_rnw = 1'b0;
        w_ld_di = {3'd0, w_shadow_nxt};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_mode   <= '0;
      r_shadow <= '0;
      r_auto   <= (AUTOLOAD_EN != 0);
      r_done   <= 1'b0;
      r_ld_en  <= 1'b0;
      r_ld_ncs <= 1'b1;
      r_ld_rnw <= 1'b1;
      r_ld_rs  <= 1'b0;
      r_ld_di  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gap    <= w_gap_nxt;
      r_mode   <= w_mode_nxt;
      r_shadow <= w_shadow_nxt;
      r_auto   <= 1'b0;
      r_done   <= w_done_nxt;
      r_ld_en  <= w_ld_en;
      r_ld_ncs <= w_ld_ncs;
      r_ld_rnw <= w_ld_rnw;
      r_ld_rs  <= w_ld_rs;
      r_ld_di  <= w_ld_di;
    end
  end

  assign crtc_enable = w_grant ? cpu_en  : r_ld_en;
  assign crtc_ncs    = w_grant ? cpu_ncs : r_ld_ncs;
  assign crtc_rnw    = w_grant ? cpu_rnw : r_ld_rnw;
  assign crtc_rs     = w_grant ? cpu_rs  : r_ld_rs;
  assign crtc_di     = w_grant ? cpu_di  : r_ld_di;
  assign cpu_do      = crtc_do;
  assign load_busy   = (r_state != ST_IDLE);
  assign load_done   = r_done;

endmodule
